mips_multicycle_controller: RTL and testbench

Multicycle control FSM that sequences the MIPS datapath (PC, unified instruction/data memory, instruction register, register file, ALU) over several cycles per instruction. It replaces single-cycle combinational control so one ALU and one memory port are shared across fetch, address calculation and execution. It decodes opcode/func from the instruction register and issues per-cycle datapath strobes. A ready/request handshake tolerates variable-latency memory.

---
 rtl/mips_ctrl_pkg.sv | 69 ++++++
 rtl/mips_multicycle_controller_if.sv | 26 ++
 rtl/mips_instr_decode.sv | 42 ++++
 rtl/mips_multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - state_t       : controller FSM states
//   - OP_* / FUNC_* : supported opcode and R-type func encodings
//   - alu_op_t      : direct ALU control (ADD/SUB/AND/OR)
//   - alu_src_b_t   : ALU B-operand mux select
//   - pc_source_t   : PC next-value mux select
//   - instr_class_t : decoded instruction class
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_R_WB,
        ST_EXEC_I,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_B_REG      = 2'b00,
        SRC_B_FOUR     = 2'b01,
        SRC_B_IMM      = 2'b10,
        SRC_B_IMM_SHL2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_source_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ADDI,
        CLS_J,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Memory handshake between the controller and the unified memory port.
//   mem_req   : request, held until mem_ready is seen
//   mem_write : 1 = write, meaningful only with mem_req
//   iord      : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current request this cycle
// master = controller side, slave = memory side.
interface mips_multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mips_instr_decode.sv
// Combinational instruction classifier.
//   opcode      in  : IR[31:26]
//   func        in  : IR[5:0]
//   instr_class out : class of the instruction in IR
//   r_alu_op    out : ALU operation for a legal R-type func (ADD otherwise)
//   legal       out : 1 when the opcode/func pair is supported
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   func,
    output instr_class_t instr_class,
    output alu_op_t      r_alu_op,
    output logic         legal
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        r_alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FUNC_ADD: begin instr_class = CLS_RTYPE; r_alu_op = ALU_ADD; end
                    FUNC_SUB: begin instr_class = CLS_RTYPE; r_alu_op = ALU_SUB; end
                    FUNC_AND: begin instr_class = CLS_RTYPE; r_alu_op = ALU_AND; end
                    FUNC_OR:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_OR;  end
                    default:  instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   instr_class = CLS_LW;
            OP_SW:   instr_class = CLS_SW;
            OP_BEQ:  instr_class = CLS_BEQ;
            OP_ADDI: instr_class = CLS_ADDI;
            OP_J:    instr_class = CLS_J;
            default: instr_class = CLS_ILLEGAL;
        endcase
        legal = (instr_class != CLS_ILLEGAL);
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch, decode, address calculation,
// execute, memory access and write-back over one shared ALU and memory port.
//   clk           in  : clock, rising edge
//   rst           in  : asynchronous active-low reset
//   opcode, func  in  : IR[31:26], IR[5:0]
//   zero          in  : ALU zero flag (consumed by the datapath PC gating)
//   mem           if  : memory handshake (master modport)
//   ir_write      out : load IR (fetch completion cycle only)
//   pc_write      out : unconditional PC load
//   pc_write_cond out : PC load when zero=1
//   pc_source     out : 00 ALU, 01 ALUOut, 10 jump target
//   alu_src_a     out : 0 PC, 1 register A
//   alu_src_b     out : 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op        out : 00 ADD, 01 SUB, 10 AND, 11 OR
//   reg_dst       out : 0 rt, 1 rd
//   mem_to_reg    out : 0 ALUOut, 1 MDR
//   reg_write     out : register file write enable
//   illegal       out : sticky unsupported-instruction flag
//   retired       out : completed-instruction count, wraps
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0]                   opcode,
    input  logic [5:0]                   func,
    input  logic                         zero,
    mips_multicycle_controller_if.master mem,
    output logic                         ir_write,
    output logic                         pc_write,
    output logic                         pc_write_cond,
    output logic [1:0]                   pc_source,
    output logic                         alu_src_a,
    output logic [1:0]                   alu_src_b,
    output logic [1:0]                   alu_op,
    output logic                         reg_dst,
    output logic                         mem_to_reg,
    output logic                         reg_write,
    output logic                         illegal,
    output logic [RETIRE_W-1:0]          retired
);

    state_t       state;
    state_t       next_state;
    instr_class_t instr_class;
    alu_op_t      r_alu_op;
    logic         legal;
    logic         retire_now;

    // The branch decision is made in the datapath (pc_write_cond AND zero),
    // so the controller itself never needs the flag.
    logic unused_zero;
    assign unused_zero = zero;

    mips_instr_decode u_decode (
        .opcode      (opcode),
        .func        (func),
        .instr_class (instr_class),
        .r_alu_op    (r_alu_op),
        .legal       (legal)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_START;
        else      state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_START:     next_state = ST_FETCH;
            ST_FETCH:     if (mem.mem_ready) next_state = ST_DECODE;
            ST_DECODE: begin
                case (instr_class)
                    CLS_LW, CLS_SW: next_state = ST_MEM_ADDR;
                    CLS_RTYPE:      next_state = ST_EXEC_R;
                    CLS_ADDI:       next_state = ST_EXEC_I;
                    CLS_BEQ:        next_state = ST_BRANCH;
                    CLS_J:          next_state = ST_JUMP;
                    default:        next_state = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR:  next_state = (instr_class == CLS_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem.mem_ready) next_state = ST_MEM_WB;
            ST_MEM_WB:    next_state = ST_FETCH;
            ST_MEM_WRITE: if (mem.mem_ready) next_state = ST_FETCH;
            ST_EXEC_R:    next_state = ST_R_WB;
            ST_R_WB:      next_state = ST_FETCH;
            ST_EXEC_I:    next_state = ST_I_WB;
            ST_I_WB:      next_state = ST_FETCH;
            ST_BRANCH:    next_state = ST_FETCH;
            ST_JUMP:      next_state = ST_FETCH;
            ST_TRAP:      next_state = ST_FETCH;
            default:      next_state = ST_START;
        endcase
    end

    // Output decode: Moore on state, except the fetch-completion strobes,
    // which must fire only in the cycle memory actually returns the word.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        case (state)
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = SRC_B_FOUR;
                ir_write    = mem.mem_ready;
                pc_write    = mem.mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target lands in ALUOut.
                alu_src_b = SRC_B_IMM_SHL2;
            end
            ST_MEM_ADDR, ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_READ: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
            end
            ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

    // An instruction retires on the transition out of its final state;
    // TRAP is deliberately absent.
    always_comb begin
        case (state)
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: retire_now = 1'b1;
            ST_MEM_WRITE: retire_now = mem.mem_ready;
            default:      retire_now = 1'b0;
        endcase
    end

    // Sticky illegal flag (visible from the TRAP cycle on) and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (next_state == ST_TRAP && !legal) illegal <= 1'b1;
            if (retire_now) retired <= retired + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller: a table of per-cycle
// vectors for a zero-wait instruction stream, plus directed sequences for
// memory wait states, reset during a store, and mem_ready held high.
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        zero = 1'b0;
    logic        ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    mips_multicycle_controller_if mem_bus ();

    mips_multicycle_controller #(.RETIRE_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .func          (func),
        .zero          (zero),
        .mem           (mem_bus),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal       (illegal),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic        zero;
        logic        rdy;
        logic [16:0] exp_ctrl;
        logic        exp_ill;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    // Expected control words, one per state signature.
    logic [16:0] C_ZERO, C_FETCH, C_FETCH_RDY, C_DECODE, C_MEM_ADDR, C_MEM_READ;
    logic [16:0] C_MEM_WB, C_MEM_WRITE, C_EXEC_ADD, C_EXEC_SUB, C_EXEC_AND;
    logic [16:0] C_EXEC_OR, C_R_WB, C_I_WB, C_BRANCH, C_JUMP;

    function automatic logic [16:0] cw(
        input logic mreq, mwr, io, irw, pcw, pcwc,
        input logic [1:0] pcs,
        input logic asa,
        input logic [1:0] asb, aop,
        input logic rd, m2r, rw);
        return {mreq, mwr, io, irw, pcw, pcwc, pcs, asa, asb, aop, rd, m2r, rw};
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return {mem_bus.mem_req, mem_bus.mem_write, mem_bus.iord, ir_write, pc_write,
                pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
                reg_dst, mem_to_reg, reg_write};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic rdy, input logic [16:0] ctrl,
                           input logic ill, input logic [31:0] ret);
        vec_t v;
        v = '{op, fn, z, rdy, ctrl, ill, ret};
        vecs.push_back(v);
    endtask

    // Drive inputs (at negedge), let comb logic settle, compare.
    task automatic apply_check(input vec_t v, input string name);
        opcode = v.opcode;
        func = v.func;
        zero = v.zero;
        mem_bus.mem_ready = v.rdy;
        #1;
        check({name, "_ctrl"}, {15'd0, dut_ctrl()}, {15'd0, v.exp_ctrl});
        check({name, "_illegal"}, {31'd0, illegal}, {31'd0, v.exp_ill});
        check({name, "_retired"}, retired, v.exp_ret);
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rdy, input logic [16:0] ctrl,
                        input logic ill, input logic [31:0] ret, input string name);
        vec_t v;
        v = '{op, fn, z, rdy, ctrl, ill, ret};
        apply_check(v, name);
        advance();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check({name, "_ctrl"}, {15'd0, dut_ctrl()}, 32'd0);
        check({name, "_illegal"}, {31'd0, illegal}, 32'd0);
        check({name, "_retired"}, retired, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        C_ZERO      = '0;
        C_FETCH     = cw(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0);
        C_FETCH_RDY = cw(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0);
        C_DECODE    = cw(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0);
        C_MEM_ADDR  = cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0);
        C_MEM_READ  = cw(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
        C_MEM_WB    = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1);
        C_MEM_WRITE = cw(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
        C_EXEC_ADD  = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b00,0,0,0);
        C_EXEC_SUB  = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,0,0);
        C_EXEC_AND  = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0);
        C_EXEC_OR   = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b11,0,0,0);
        C_R_WB      = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1);
        C_I_WB      = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1);
        C_BRANCH    = cw(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0);
        C_JUMP      = cw(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0);

        // Zero-wait instruction stream, one row per cycle starting in START.
        // add
        add_vec(6'h00, 6'h20, 0, 1, C_ZERO,      0, 0);
        add_vec(6'h00, 6'h20, 0, 1, C_FETCH_RDY, 0, 0);
        add_vec(6'h00, 6'h20, 0, 1, C_DECODE,    0, 0);
        add_vec(6'h00, 6'h20, 0, 0, C_EXEC_ADD,  0, 0);
        add_vec(6'h00, 6'h20, 0, 0, C_R_WB,      0, 0);
        // sub
        add_vec(6'h00, 6'h22, 0, 1, C_FETCH_RDY, 0, 1);
        add_vec(6'h00, 6'h22, 0, 0, C_DECODE,    0, 1);
        add_vec(6'h00, 6'h22, 0, 1, C_EXEC_SUB,  0, 1);
        add_vec(6'h00, 6'h22, 0, 0, C_R_WB,      0, 1);
        // addi, with one fetch wait cycle
        add_vec(6'h08, 6'h00, 0, 0, C_FETCH,     0, 2);
        add_vec(6'h08, 6'h00, 0, 1, C_FETCH_RDY, 0, 2);
        add_vec(6'h08, 6'h00, 0, 0, C_DECODE,    0, 2);
        add_vec(6'h08, 6'h00, 0, 0, C_MEM_ADDR,  0, 2);
        add_vec(6'h08, 6'h00, 0, 1, C_I_WB,      0, 2);
        // and
        add_vec(6'h00, 6'h24, 0, 1, C_FETCH_RDY, 0, 3);
        add_vec(6'h00, 6'h24, 0, 0, C_DECODE,    0, 3);
        add_vec(6'h00, 6'h24, 0, 0, C_EXEC_AND,  0, 3);
        add_vec(6'h00, 6'h24, 0, 0, C_R_WB,      0, 3);
        // or
        add_vec(6'h00, 6'h25, 0, 1, C_FETCH_RDY, 0, 4);
        add_vec(6'h00, 6'h25, 0, 0, C_DECODE,    0, 4);
        add_vec(6'h00, 6'h25, 0, 0, C_EXEC_OR,   0, 4);
        add_vec(6'h00, 6'h25, 0, 0, C_R_WB,      0, 4);
        // beq taken / not taken: controller output identical, 3 cycles each
        add_vec(6'h04, 6'h00, 1, 1, C_FETCH_RDY, 0, 5);
        add_vec(6'h04, 6'h00, 1, 0, C_DECODE,    0, 5);
        add_vec(6'h04, 6'h00, 1, 0, C_BRANCH,    0, 5);
        add_vec(6'h04, 6'h00, 0, 1, C_FETCH_RDY, 0, 6);
        add_vec(6'h04, 6'h00, 0, 0, C_DECODE,    0, 6);
        add_vec(6'h04, 6'h00, 0, 1, C_BRANCH,    0, 6);
        // sw, zero-wait
        add_vec(6'h2B, 6'h00, 0, 1, C_FETCH_RDY, 0, 7);
        add_vec(6'h2B, 6'h00, 0, 0, C_DECODE,    0, 7);
        add_vec(6'h2B, 6'h00, 0, 0, C_MEM_ADDR,  0, 7);
        add_vec(6'h2B, 6'h00, 0, 1, C_MEM_WRITE, 0, 7);
        // lw, zero-wait
        add_vec(6'h23, 6'h00, 0, 1, C_FETCH_RDY, 0, 8);
        add_vec(6'h23, 6'h00, 0, 0, C_DECODE,    0, 8);
        add_vec(6'h23, 6'h00, 0, 0, C_MEM_ADDR,  0, 8);
        add_vec(6'h23, 6'h00, 0, 1, C_MEM_READ,  0, 8);
        add_vec(6'h23, 6'h00, 0, 0, C_MEM_WB,    0, 8);
        // illegal opcode 0x3F
        add_vec(6'h3F, 6'h00, 0, 1, C_FETCH_RDY, 0, 9);
        add_vec(6'h3F, 6'h00, 0, 0, C_DECODE,    0, 9);
        add_vec(6'h3F, 6'h00, 0, 1, C_ZERO,      1, 9);
        // illegal R-type func 0x27
        add_vec(6'h00, 6'h27, 0, 1, C_FETCH_RDY, 1, 9);
        add_vec(6'h00, 6'h27, 0, 0, C_DECODE,    1, 9);
        add_vec(6'h00, 6'h27, 0, 0, C_ZERO,      1, 9);
        // j
        add_vec(6'h02, 6'h00, 0, 1, C_FETCH_RDY, 1, 9);
        add_vec(6'h02, 6'h00, 0, 0, C_DECODE,    1, 9);
        add_vec(6'h02, 6'h00, 0, 0, C_JUMP,      1, 9);
        add_vec(6'h00, 6'h20, 0, 0, C_FETCH,     1, 10);

        do_reset("reset0");
        foreach (vecs[i]) begin
            apply_check(vecs[i], $sformatf("row%0d", i));
            advance();
        end

        // lw with three memory wait cycles in MEM_READ: 8 cycles fetch to fetch.
        do_reset("reset1");
        step(6'h23, 6'h00, 0, 0, C_ZERO,      0, 0, "lw_start");
        step(6'h23, 6'h00, 0, 1, C_FETCH_RDY, 0, 0, "lw_fetch");
        step(6'h23, 6'h00, 0, 0, C_DECODE,    0, 0, "lw_decode");
        step(6'h23, 6'h00, 0, 0, C_MEM_ADDR,  0, 0, "lw_addr");
        for (int w = 0; w < 3; w++)
            step(6'h23, 6'h00, 0, 0, C_MEM_READ, 0, 0, $sformatf("lw_wait%0d", w));
        step(6'h23, 6'h00, 0, 1, C_MEM_READ,  0, 0, "lw_read_rdy");
        step(6'h23, 6'h00, 0, 0, C_MEM_WB,    0, 0, "lw_wb");
        // sw interrupted by reset while waiting on memory.
        step(6'h2B, 6'h00, 0, 1, C_FETCH_RDY, 0, 1, "sw_fetch");
        step(6'h2B, 6'h00, 0, 0, C_DECODE,    0, 1, "sw_decode");
        step(6'h2B, 6'h00, 0, 0, C_MEM_ADDR,  0, 1, "sw_addr");
        step(6'h2B, 6'h00, 0, 0, C_MEM_WRITE, 0, 1, "sw_wait");
        apply_check('{6'h2B, 6'h00, 1'b0, 1'b0, C_MEM_WRITE, 1'b0, 32'd1}, "sw_wait2");
        rst = 1'b0;
        #1;
        check("sw_rst_ctrl", {15'd0, dut_ctrl()}, 32'd0);
        check("sw_rst_mem_write", {31'd0, mem_bus.mem_write}, 32'd0);
        check("sw_rst_retired", retired, 32'd0);
        @(negedge clk);
        // mem_ready arriving while in reset must not advance anything.
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        // Restart via START, then j with mem_ready held high throughout.
        step(6'h02, 6'h00, 0, 1, C_ZERO,      0, 0, "j_start");
        step(6'h02, 6'h00, 0, 1, C_FETCH_RDY, 0, 0, "j_fetch");
        step(6'h02, 6'h00, 0, 1, C_DECODE,    0, 0, "j_decode");
        step(6'h02, 6'h00, 0, 1, C_JUMP,      0, 0, "j_jump");
        step(6'h02, 6'h00, 0, 1, C_FETCH_RDY, 0, 1, "j_fetch2");
        step(6'h02, 6'h00, 0, 1, C_DECODE,    0, 1, "j_decode2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
